// File: rtl/png_pkg.sv
// Shared constants, tag widths and FSM state type for the PNG frame packer.
package png_pkg;

  localparam int FRAME_BYTES = 69;
  localparam int IP_W        = 32;
  localparam int PORT_W      = 16;
  localparam int SIG_BYTES   = 8;

  localparam logic [63:0] PNG_SIG = 64'h89504E470D0A1A0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Byte idx (0 = first on the wire) of the eight-byte PNG signature.
  function automatic logic [7:0] sig_byte(input logic [2:0] idx);
    return PNG_SIG[63 - 8*idx -: 8];
  endfunction

endpackage

// File: rtl/png_sig_check.sv
// On-the-fly comparator for the first eight bytes of a frame against the PNG
// signature. The mismatch flag is sticky until the next frame start.
module png_sig_check
  import png_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       data,
  input  logic [CNT_W-1:0] index,
  input  logic             accept,
  output logic             mismatch
);

  logic in_sig;
  logic bad_byte;

  assign in_sig   = (index < CNT_W'(SIG_BYTES));
  assign bad_byte = accept && in_sig && (data != sig_byte(index[2:0]));

  // A frame start restarts the comparison; the start cycle's byte is byte 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch <= 1'b0;
    end else if (clr) begin
      mismatch <= bad_byte;
    end else if (bad_byte) begin
      mismatch <= 1'b1;
    end
  end

endmodule

// File: rtl/png_frame_packer.sv
// Byte-stream receive packer: collects FRAME_BYTES bytes into one wide frame
// word tagged with source ip/port and holds it for a valid/ready consumer.
// Optional build macro PNG_SIG_CHECK_EN adds the PNG signature checker and
// the sig_err output.
module png_frame_packer #(
  parameter  int FRAME_BYTES = png_pkg::FRAME_BYTES,
  parameter  int CNT_W       = 7,
  localparam int DATA_W      = FRAME_BYTES * 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              istart,
  input  logic              ivalid,
  input  logic [7:0]        ibyte,
  output logic              iready,
  input  logic [31:0]       ip_in,
  input  logic [15:0]       port_in,
  output logic [DATA_W-1:0] frame_out,
  output logic [31:0]       ip_out,
  output logic [15:0]       port_out,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [CNT_W-1:0]  byte_count,
  output logic              abort,
  output logic              drop
`ifdef PNG_SIG_CHECK_EN
  ,
  output logic              sig_err
`endif
);

  import png_pkg::*;

  localparam int POS_W = $clog2(DATA_W);

  state_t           state;
  logic             start_ok;
  logic             byte_wr;
  logic             last_byte;
  logic [CNT_W-1:0] wr_idx;
  logic [POS_W-1:0] bit_hi;

  // A start restarts the frame, so its same-cycle byte lands at index 0.
  assign start_ok  = istart && iready;
  assign byte_wr   = ivalid && iready && ((state == FILL) || istart);
  assign wr_idx    = istart ? '0 : byte_count;
  assign last_byte = (wr_idx == CNT_W'(FRAME_BYTES - 1));
  assign bit_hi    = POS_W'(DATA_W - 1 - 8 * int'(wr_idx));

  // Control FSM with registered handshake, tag, frame and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      iready      <= 1'b0;
      frame_valid <= 1'b0;
      byte_count  <= '0;
      frame_out   <= '0;
      ip_out      <= '0;
      port_out    <= '0;
      abort       <= 1'b0;
      drop        <= 1'b0;
    end else begin
      abort <= 1'b0;
      drop  <= 1'b0;
      case (state)
        IDLE, FILL: begin
          iready <= 1'b1;
          if (start_ok) begin
            ip_out     <= ip_in;
            port_out   <= port_in;
            frame_out  <= '0;
            byte_count <= '0;
            state      <= FILL;
            if (state == FILL) abort <= 1'b1;
          end else if ((state == IDLE) && (istart || ivalid)) begin
            drop <= 1'b1;
          end
          if (byte_wr) begin
            frame_out[bit_hi -: 8] <= ibyte;
            byte_count             <= wr_idx + CNT_W'(1);
            if (last_byte) begin
              state       <= HOLD;
              frame_valid <= 1'b1;
              iready      <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (frame_ready) begin
            state       <= IDLE;
            frame_valid <= 1'b0;
            byte_count  <= '0;
            iready      <= 1'b1;
          end
          if (istart || ivalid) drop <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          iready <= 1'b1;
        end
      endcase
    end
  end

`ifdef PNG_SIG_CHECK_EN
  logic sig_mismatch;

  png_sig_check #(
    .CNT_W(CNT_W)
  ) u_sig_check (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .data     (ibyte),
    .index    (wr_idx),
    .accept   (byte_wr),
    .mismatch (sig_mismatch)
  );

  assign sig_err = frame_valid && sig_mismatch;
`endif

endmodule

// File: tb/tb_png_frame_packer.sv
// Directed self-checking bench for png_frame_packer.
module tb_png_frame_packer;

  localparam int FB    = 69;
  localparam int DW    = FB * 8;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             istart;
  logic             ivalid;
  logic [7:0]       ibyte;
  logic             iready;
  logic [31:0]      ip_in;
  logic [15:0]      port_in;
  logic [DW-1:0]    frame_out;
  logic [31:0]      ip_out;
  logic [15:0]      port_out;
  logic             frame_valid;
  logic             frame_ready;
  logic [CNT_W-1:0] byte_count;
  logic             abort;
  logic             drop;
`ifdef PNG_SIG_CHECK_EN
  logic             sig_err;
`endif

  logic [7:0] tbl [FB];
  int n_cmp = 0;
  int n_bad = 0;
  int drop_cnt = 0;
  int abort_cnt = 0;

  png_frame_packer #(
    .FRAME_BYTES(FB),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .istart     (istart),
    .ivalid     (ivalid),
    .ibyte      (ibyte),
    .iready     (iready),
    .ip_in      (ip_in),
    .port_in    (port_in),
    .frame_out  (frame_out),
    .ip_out     (ip_out),
    .port_out   (port_out),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .byte_count (byte_count),
    .abort      (abort),
    .drop       (drop)
`ifdef PNG_SIG_CHECK_EN
    ,
    .sig_err    (sig_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    drop_cnt  += int'(drop);
    abort_cnt += int'(abort);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic start_frame(input logic [31:0] ip, input logic [15:0] port, input logic [7:0] b0);
    istart  = 1'b1;
    ivalid  = 1'b1;
    ibyte   = b0;
    ip_in   = ip;
    port_in = port;
    step();
    istart  = 1'b0;
    ivalid  = 1'b0;
  endtask

  task automatic feed(input int lo, input int hi, input bit gapped);
    for (int i = lo; i <= hi; i++) begin
      if (gapped) begin
        ivalid = 1'b0;
        step();
      end
      ivalid = 1'b1;
      ibyte  = tbl[i];
      step();
    end
    ivalid = 1'b0;
  endtask

  task automatic release_frame();
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_frame(input logic [7:0] b0);
    logic [DW-1:0] f;
    for (int i = 0; i < FB; i++) f[DW-1-8*i -: 8] = tbl[i];
    f[DW-1 -: 8] = b0;
    return f;
  endfunction

  initial begin
    logic [DW-1:0] good;
    logic [DW-1:0] head;
    tbl = '{8'h89, 8'h50, 8'h4E, 8'h47, 8'h0D, 8'h0A, 8'h1A, 8'h0A,
            8'h00, 8'h00, 8'h00, 8'h0D, 8'h49, 8'h48, 8'h44, 8'h52,
            8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
            8'h08, 8'h06, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h15, 8'hC4, 8'h89,
            8'h00, 8'h00, 8'h00, 8'h0C, 8'h49, 8'h44, 8'h41, 8'h54,
            8'h08, 8'hD7, 8'h63, 8'hF8, 8'hCF, 8'hC0, 8'h00, 8'h00,
            8'h03, 8'h01, 8'h01, 8'h00, 8'h18, 8'hDD, 8'h8D, 8'hB0,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h49, 8'h45, 8'h4E, 8'h44,
            8'hAE, 8'h42, 8'h60, 8'h82};
    good = exp_frame(8'h89);

    rst = 1'b1; istart = 1'b0; ivalid = 1'b0; ibyte = '0;
    ip_in = '0; port_in = '0; frame_ready = 1'b0;
    step();
    step();
    chk("rst_iready", DW'(iready), '0);
    chk("rst_valid", DW'(frame_valid), '0);
    chk("rst_frame", frame_out, '0);
    chk("rst_ip", DW'(ip_out), '0);
    chk("rst_port", DW'(port_out), '0);
    chk("rst_count", DW'(byte_count), '0);
    chk("rst_pulses", DW'({drop, abort}), '0);
    rst = 1'b0;
    step();
    chk("idle_iready", DW'(iready), DW'(1));

    // Full back-to-back frame
    drop_cnt = 0; abort_cnt = 0;
    start_frame(32'hC0A80001, 16'h1F90, tbl[0]);
    chk("t1_count1", DW'(byte_count), DW'(1));
    feed(1, 67, 1'b0);
    chk("t1_valid_early", DW'(frame_valid), '0);
    chk("t1_count68", DW'(byte_count), DW'(68));
    feed(68, 68, 1'b0);
    chk("t1_valid", DW'(frame_valid), DW'(1));
    chk("t1_count69", DW'(byte_count), DW'(69));
    chk("t1_frame", frame_out, good);
    chk("t1_first", DW'(frame_out[DW-1 -: 8]), DW'(8'h89));
    chk("t1_last", DW'(frame_out[7:0]), DW'(8'h82));
    chk("t1_ip", DW'(ip_out), DW'(32'hC0A80001));
    chk("t1_port", DW'(port_out), DW'(16'h1F90));
    chk("t1_iready", DW'(iready), '0);
    chk("t1_drops", DW'(drop_cnt), '0);
    chk("t1_aborts", DW'(abort_cnt), '0);
`ifdef PNG_SIG_CHECK_EN
    chk("t1_sig_err", DW'(sig_err), '0);
`endif
    release_frame();
    chk("t1_rel_valid", DW'(frame_valid), '0);
    chk("t1_rel_count", DW'(byte_count), '0);
    chk("t1_rel_iready", DW'(iready), DW'(1));

    // Gapped stream with delayed consumer
    start_frame(32'hC0A80001, 16'h1F90, tbl[0]);
    feed(1, 68, 1'b1);
    chk("t2_valid", DW'(frame_valid), DW'(1));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_hold_frame", frame_out, good);
      chk("t2_hold_valid", DW'(frame_valid), DW'(1));
    end
    release_frame();
    chk("t2_rel_valid", DW'(frame_valid), '0);
    chk("t2_rel_count", DW'(byte_count), '0);
    chk("t2_rel_frame_kept", frame_out, good);

    // Abort by a new start mid-frame
    abort_cnt = 0;
    start_frame(32'hC0A80001, 16'h1F90, 8'hA5);
    for (int i = 1; i < 20; i++) begin
      ivalid = 1'b1; ibyte = 8'hA5;
      step();
    end
    chk("t3_count20", DW'(byte_count), DW'(20));
    start_frame(32'h0A000001, 16'h0050, tbl[0]);
    chk("t3_abort", DW'(abort), DW'(1));
    chk("t3_count1", DW'(byte_count), DW'(1));
    chk("t3_ip", DW'(ip_out), DW'(32'h0A000001));
    head = '0;
    head[DW-1 -: 8] = tbl[0];
    chk("t3_cleared", frame_out, head);
    feed(1, 68, 1'b0);
    chk("t3_abort_once", DW'(abort_cnt), DW'(1));
    chk("t3_frame", frame_out, good);
    chk("t3_port", DW'(port_out), DW'(16'h0050));
    release_frame();

    // Drops in IDLE and HOLD
    drop_cnt = 0;
    ivalid = 1'b1; ibyte = 8'h55;
    step();
    ivalid = 1'b0;
    chk("t4_idle_drop", DW'(drop), DW'(1));
    chk("t4_idle_frame", frame_out, good);
    chk("t4_idle_count", DW'(byte_count), '0);
    start_frame(32'hC0A80001, 16'h1F90, tbl[0]);
    feed(1, 68, 1'b0);
    ip_in = 32'hDEADBEEF; port_in = 16'h1234;
    istart = 1'b1;
    step();
    istart = 1'b0;
    ivalid = 1'b1; ibyte = 8'h00;
    step();
    ivalid = 1'b0;
    chk("t4_drop_cnt", DW'(drop_cnt), DW'(3));
    chk("t4_frame", frame_out, good);
    chk("t4_ip", DW'(ip_out), DW'(32'hC0A80001));
    chk("t4_port", DW'(port_out), DW'(16'h1F90));
    chk("t4_valid", DW'(frame_valid), DW'(1));
    release_frame();

    // Reset mid-frame
    abort_cnt = 0;
    start_frame(32'hC0A80001, 16'h1F90, tbl[0]);
    feed(1, 39, 1'b0);
    chk("t5_count40", DW'(byte_count), DW'(40));
    rst = 1'b1; ivalid = 1'b1; ibyte = tbl[40];
    step();
    ivalid = 1'b0;
    chk("t5_frame", frame_out, '0);
    chk("t5_count", DW'(byte_count), '0);
    chk("t5_tags", DW'({ip_out, port_out}), '0);
    chk("t5_ctrl", DW'({iready, frame_valid, abort, drop}), '0);
    chk("t5_no_abort", DW'(abort_cnt), '0);
    rst = 1'b0;
    step();
    start_frame(32'hC0A80001, 16'h1F90, tbl[0]);
    feed(1, 68, 1'b0);
    chk("t5_clean_frame", frame_out, good);
    chk("t5_clean_valid", DW'(frame_valid), DW'(1));
    chk("t5_clean_ip", DW'(ip_out), DW'(32'hC0A80001));
    release_frame();

`ifdef PNG_SIG_CHECK_EN
    // Signature checking
    start_frame(32'hC0A80001, 16'h1F90, 8'h88);
    feed(1, 68, 1'b0);
    chk("t6_bad_valid", DW'(frame_valid), DW'(1));
    chk("t6_bad_sig_err", DW'(sig_err), DW'(1));
    chk("t6_bad_frame", frame_out, exp_frame(8'h88));
    release_frame();
    chk("t6_rel_sig_err", DW'(sig_err), '0);
    start_frame(32'hC0A80001, 16'h1F90, tbl[0]);
    feed(1, 68, 1'b0);
    chk("t6_good_valid", DW'(frame_valid), DW'(1));
    chk("t6_good_sig_err", DW'(sig_err), '0);
    release_frame();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/png_frame_packer.md
Name: png_frame_packer

Overview:
- Receive side of the byte-stream link (istart/ivalid/iready/ibyte) that feeds the PNG decoder path.
- Accepts a serial byte stream and reassembles it into one wide frame word tagged with the source ip/port.
- Presents the frame downstream with a valid/ready handshake, so a captured stream can be reloaded or compared.

Parameters:
- FRAME_BYTES, 69, number of bytes per frame.
- DATA_W, FRAME_BYTES*8 (552), width of the frame word; derived, not overridden.
- CNT_W, 7, width of the byte counter; must satisfy 2^CNT_W > FRAME_BYTES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- istart  input  1  one-cycle frame-start pulse.
- ivalid  input  1  ibyte holds a valid byte.
- ibyte  input  8  stream byte.
- iready  output  1  packer can accept a byte.
- ip_in  input  32  source IP; sampled on accepted istart.
- port_in  input  16  source port; sampled on accepted istart.
- frame_out  output  DATA_W  assembled frame; first byte received in [DATA_W-1 -: 8].
- ip_out  output  32  tag of the held frame.
- port_out  output  16  tag of the held frame.
- frame_valid  output  1  frame_out is complete and held.
- frame_ready  input  1  downstream accepts the frame.
- byte_count  output  CNT_W  bytes accepted in the current frame.
- abort  output  1  one-cycle pulse: partial frame discarded by a new istart.
- drop  output  1  one-cycle pulse: byte or istart ignored.

Behaviour:
- Reset: state IDLE; all outputs 0, including frame_out, ip_out, port_out, byte_count and iready. Reset mid-frame discards everything with no abort pulse.
- FSM states IDLE, FILL, HOLD. iready=1 in IDLE and FILL; iready=0 in HOLD.
- IDLE:
  - istart: latch ip_in/port_in, clear frame_out and byte_count, go to FILL.
  - istart with ivalid in the same cycle: the byte is accepted as byte 0.
  - ivalid without istart: byte ignored, drop pulses.
- FILL:
  - Each ivalid&&iready cycle writes ibyte to frame_out[DATA_W-1-8*byte_count -: 8] and increments byte_count.
  - Write latency is 1 cycle.
  - Accepting byte FRAME_BYTES-1 moves to HOLD with frame_valid=1 on the next cycle; byte_count=FRAME_BYTES there.
- istart during FILL:
  - abort pulses; the new tag is latched, frame_out and byte_count clear, state stays FILL.
  - A byte in the same cycle becomes byte 0 of the new frame.
- HOLD:
  - frame_out, ip_out and port_out are stable while frame_valid=1.
  - frame_valid&&frame_ready goes to IDLE; frame_valid drops and byte_count clears next cycle. frame_out keeps its value until the next istart.
  - istart or ivalid in HOLD: ignored, drop pulses (no back-pressure on istart).
- frame_ready outside HOLD has no effect.
- byte_count never wraps: at most FRAME_BYTES.

Optional Feature:
- Macro PNG_SIG_CHECK_EN.
- When defined:
  - Bytes 0..7 are compared on the fly against 89 50 4E 47 0D 0A 1A 0A.
  - Extra output sig_err (1 bit, reset 0) asserts with frame_valid when any mismatch occurred; it clears on istart.
  - The frame is still delivered.
- When undefined: no comparator; sig_err is absent from the port list.

Decomposition:
- Package png_pkg: FRAME_BYTES, PNG_SIG (64'h89504E470D0A1A0A), the state enum, and default tag widths (IP_W=32, PORT_W=16).
- One sub-module png_sig_check, instantiated only under PNG_SIG_CHECK_EN. Inputs are byte, index and accept strobe; output is the sticky mismatch flag.

Test Plan:
- Full frame: istart with ip=C0A80001 and port=1F90, then 69 back-to-back bytes of the test PNG (89504E47…AE426082) -> frame_out equals that 552-bit value, frame_valid 1 cycle after the last byte, tags match, drop=abort=0.
- Gapped stream: ivalid toggles every other cycle; frame_ready is held low 5 cycles, then high -> identical frame; stable during HOLD; IDLE next cycle with byte_count=0.
- Abort: 20 bytes, then istart with ip=0A000001 plus a byte in the same cycle -> abort pulses once, byte_count=1, and the final frame contains only the new bytes.
- Drops: ivalid in IDLE without istart, then istart and ivalid in HOLD -> 3 drop pulses; frame_out and tags unchanged.
- Reset: rst at byte 40 -> next cycle all outputs 0 and IDLE; a following clean frame assembles correctly.
- PNG_SIG_CHECK_EN: first byte 88 instead of 89 -> sig_err=1 with frame_valid. A correct signature -> sig_err=0.
